fetch_engine: RTL

FETCH_ENGINE -- requirements
Module: fetch_engine

---
 rtl/fetch_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fetch_engine.sv
// Line transfer engine: moves one cache line between cache memory and external
// memory one word at a time, keeping exactly one word in flight on each side.
module fetch_engine #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32,
  localparam int TW = $clog2(list_depth),
  localparam int WW = $clog2(list_width)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [1:0]            fetch_cmd,
  input  logic [TW-1:0]         fetch_tag,
  input  logic [addr_width-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_done,
  output logic                  mem_ren,
  output logic [TW+WW-1:0]      mem_raddr,
  input  logic                  mem_rready,
  input  logic [data_width-1:0] mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic [1:0]            mem_rpri,
  output logic                  mem_wen,
  output logic [TW+WW-1:0]      mem_waddr,
  output logic [data_width-1:0] mem_wdata,
  input  logic                  mem_wready,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [addr_width-1:0] ext_addr,
  output logic [data_width-1:0] ext_wdata,
  input  logic                  ext_gnt,
  input  logic [data_width-1:0] ext_rdata,
  input  logic                  ext_rdata_valid
);

  localparam int BS = $clog2(data_width / 8);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_WAIT, WB_EXT, FL_EXT, FL_WAIT, FL_WR, DONE
  } state_t;

  state_t                  state, state_nx;
  logic [1:0]              cmd_q;
  logic [TW-1:0]           tag_q;
  logic [addr_width-1:0]   addr_q;
  logic [WW-1:0]           wcnt;
  logic [data_width-1:0]   buf_q;
  logic                    wcnt_inc;
  logic                    last_word;
  logic [addr_width-1:0]   word_addr;

  assign last_word = (wcnt == WW'(list_width - 1));
  // Byte offset of the current word; the add wraps at addr_width by design.
  assign word_addr = addr_q + (addr_width'(wcnt) << BS);

  assign fetch_gnt = rst_n && (state == IDLE);
  assign mem_rpri  = 2'b01;
  assign ext_we    = ext_req && (cmd_q == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cmd_q  <= '0;
      tag_q  <= '0;
      addr_q <= '0;
      wcnt   <= '0;
      buf_q  <= '0;
    end else begin
      state <= state_nx;
      if (fetch_req && fetch_gnt) begin
        cmd_q  <= fetch_cmd;
        tag_q  <= fetch_tag;
        addr_q <= fetch_addr;
        wcnt   <= '0;
      end else if (wcnt_inc) begin
        wcnt <= wcnt + WW'(1);
      end
      if (state == WB_WAIT && mem_rdata_valid) buf_q <= mem_rdata;
      if (state == FL_WAIT && ext_rdata_valid) buf_q <= ext_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    wcnt_inc   = 1'b0;
    fetch_done = 1'b0;
    mem_ren    = 1'b0;
    mem_raddr  = '0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    ext_req    = 1'b0;
    ext_addr   = '0;
    ext_wdata  = '0;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          case (fetch_cmd)
            2'b00:   state_nx = WB_RD;
            2'b01:   state_nx = FL_EXT;
            default: state_nx = DONE;
          endcase
        end
      end
      WB_RD: begin
        mem_ren   = 1'b1;
        mem_raddr = {tag_q, wcnt};
        if (mem_rready) state_nx = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_rdata_valid) state_nx = WB_EXT;
      end
      WB_EXT: begin
        ext_req   = 1'b1;
        ext_addr  = word_addr;
        ext_wdata = buf_q;
        if (ext_gnt) begin
          if (last_word) state_nx = DONE;
          else begin
            wcnt_inc = 1'b1;
            state_nx = WB_RD;
          end
        end
      end
      FL_EXT: begin
        ext_req  = 1'b1;
        ext_addr = word_addr;
        if (ext_gnt) state_nx = FL_WAIT;
      end
      FL_WAIT: begin
        if (ext_rdata_valid) state_nx = FL_WR;
      end
      FL_WR: begin
        mem_wen   = 1'b1;
        mem_waddr = {tag_q, wcnt};
        mem_wdata = buf_q;
        if (mem_wready) begin
          if (last_word) state_nx = DONE;
          else begin
            wcnt_inc = 1'b1;
            state_nx = FL_EXT;
          end
        end
      end
      DONE: begin
        fetch_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
